fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter that gives four requesters bursts
// of up to BURST_LEN beats into one downstream FIFO write port.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   req_valid     per-requester write request (bit i = requester i)
//   req_data      requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     per-requester accept; only the owner can be ready, and only while the FIFO is not full
//   fifo_full     full flag from the downstream FIFO
//   fifo_wr_en    FIFO write strobe (a beat transfers)
//   fifo_wr_data  owner's data word
//   grant_id      current owner index, meaningful while busy=1
//   busy          an owner holds the write port
//   beat_count    four saturating 16-bit accepted-beat counters, requester i in bits [i*16 +: 16]
module fifo_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              req_valid,
    input  logic [4*DATA_WIDTH-1:0] req_data,
    output logic [3:0]              req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_wr_en,
    output logic [DATA_WIDTH-1:0]   fifo_wr_data,
    output logic [1:0]              grant_id,
    output logic                    busy,
    output logic [63:0]             beat_count
);

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned BEAT_W  = 4;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t            state;
    logic [1:0]        owner;
    logic [1:0]        rr_ptr;
    logic [BEAT_W-1:0] beat_cnt;
    logic [CNT_W-1:0]  lane_cnt [NUM_REQ];

    logic              owner_valid;
    logic              xfer;
    logic              pick_found;
    logic [1:0]        pick_idx;
    logic [1:0]        cand;

    assign owner_valid = req_valid[owner];

    // A beat moves only from the owner, with FIFO space, and never in a reset cycle.
    assign xfer       = (state == SERVE) && owner_valid && !fifo_full && !rst;
    assign fifo_wr_en = xfer;

    assign busy     = (state == SERVE);
    assign grant_id = owner;

    // Only the owner sees ready, and only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        if ((state == SERVE) && !rst) begin
            req_ready[owner] = !fifo_full;
        end
    end

    // Owner's data word steered to the FIFO.
    always_comb begin
        fifo_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == 2'(i)) begin
                fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // First valid requester searching rr_ptr, rr_ptr+1, ... modulo 4.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        cand       = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rr_ptr + 2'(k);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Flatten the per-requester counters onto the output bus.
    always_comb begin
        beat_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            beat_count[i*CNT_W +: CNT_W] = lane_cnt[i];
        end
    end

    // Arbitration state, burst tracking and accepted-beat counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                lane_cnt[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= SERVE;
                    end
                end
                SERVE: begin
                    if (!owner_valid) begin
                        // Dropping valid forfeits the remainder of the burst.
                        state  <= IDLE;
                        rr_ptr <= owner + 2'd1;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            state  <= IDLE;
                            rr_ptr <= owner + 2'd1;
                        end
                    end
                end
            endcase

            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer && (owner == 2'(i)) && (lane_cnt[i] != CNT_MAX)) begin
                    lane_cnt[i] <= lane_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: scenario tasks with a write scoreboard.
// Main instance uses BURST_LEN=4; side instances cover BURST_LEN=1 and
// counter saturation with BURST_LEN=16.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic        fifo_full;
    logic [3:0]  req_ready;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic [63:0] beat_count;

    logic [3:0]  rv1, rdy1;
    logic        wr1, busy1;
    logic [7:0]  wd1;
    logic [1:0]  gid1;
    logic [63:0] bc1;

    logic [3:0]  rv16, rdy16;
    logic        wr16, busy16;
    logic [7:0]  wd16;
    logic [1:0]  gid16;
    logic [63:0] bc16;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] exp_q [$];
    int sent_cnt [4];
    int exp_idx  [4];

    always #5 clk = ~clk;

    fifo_write_arbiter #(.DATA_WIDTH(8), .BURST_LEN(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy),
        .beat_count(beat_count)
    );

    fifo_write_arbiter #(.DATA_WIDTH(8), .BURST_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_data(req_data),
        .req_ready(rdy1), .fifo_full(fifo_full), .fifo_wr_en(wr1),
        .fifo_wr_data(wd1), .grant_id(gid1), .busy(busy1),
        .beat_count(bc1)
    );

    fifo_write_arbiter #(.DATA_WIDTH(8), .BURST_LEN(16)) dut16 (
        .clk(clk), .rst(rst), .req_valid(rv16), .req_data(req_data),
        .req_ready(rdy16), .fifo_full(fifo_full), .fifo_wr_en(wr16),
        .fifo_wr_data(wd16), .grant_id(gid16), .busy(busy16),
        .beat_count(bc16)
    );

    // Data word of requester r's k-th beat: requester in top bits, index below.
    function automatic logic [7:0] beat_data(int r, int k);
        return 8'((r << 6) | (k & 63));
    endfunction

    task automatic push_exp(int r, int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({2'(r), beat_data(r, exp_idx[r])});
            exp_idx[r]++;
        end
    endtask

    // Drive data, settle, score any write, then note accepted beats.
    task automatic sample();
        logic [9:0] e;
        for (int r = 0; r < 4; r++) req_data[r*8 +: 8] = beat_data(r, sent_cnt[r]);
        #1;
        if (fifo_wr_en === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got id=%0d data=%h, no write expected", grant_id, fifo_wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({grant_id, fifo_wr_data} !== e) begin
                    n_fail++;
                    $display("FAIL write_order: got id=%0d data=%h, expected id=%0d data=%h",
                             grant_id, fifo_wr_data, e[9:8], e[7:0]);
                end
            end
        end
        if (fifo_full) begin
            n_tests++;
            if (fifo_wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL write_while_full: got wr_en=%b, expected 0", fifo_wr_en);
            end
        end
        for (int r = 0; r < 4; r++) if (req_valid[r] && req_ready[r]) sent_cnt[r]++;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drained(string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected writes never happened", name, exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; rv1 = '0; rv16 = '0; fifo_full = 1'b0;
        exp_q.delete();
        for (int r = 0; r < 4; r++) begin sent_cnt[r] = 0; exp_idx[r] = 0; end
        sample();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; rv1 = 4'hF; rv16 = 4'hF; fifo_full = 1'b0;
        req_data = '0;
        tick();
        #1;
        n_tests++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || req_ready !== 4'h0 || fifo_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b gid=%0d ready=%b wr=%b, expected 0 0 0000 0",
                     busy, grant_id, req_ready, fifo_wr_en);
        end
        n_tests++;
        if (beat_count !== 64'd0 || bc1 !== 64'd0 || bc16 !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got %h %h %h, expected 0", beat_count, bc1, bc16);
        end
        n_tests++;
        if (busy1 !== 1'b0 || busy16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy_side: got %b %b, expected 0 0", busy1, busy16);
        end
        req_valid = '0; rv1 = '0; rv16 = '0;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int g = 0; g < 5; g++) push_exp(g % 4, 4);
        req_valid = 4'hF;
        for (int c = 0; c < 25; c++) begin
            sample();
            n_tests++;
            if (busy !== (c % 5 != 0)) begin
                n_fail++;
                $display("FAIL rr_busy c=%0d: got %b, expected %b", c, busy, (c % 5 != 0));
            end
            if (c % 5 != 0) begin
                n_tests++;
                if (grant_id !== 2'((c / 5) % 4)) begin
                    n_fail++;
                    $display("FAIL rr_grant c=%0d: got %0d, expected %0d", c, grant_id, (c / 5) % 4);
                end
            end
            if (c == 20) begin
                n_tests++;
                if (beat_count !== {4{16'd4}}) begin
                    n_fail++;
                    $display("FAIL rr_counts: got %h, expected %h", beat_count, {4{16'd4}});
                end
            end
            tick();
        end
        req_valid = '0;
        sample();
        tick();
        drained("rr_drain");
    endtask

    task automatic test_single();
        do_reset();
        push_exp(2, 8);
        req_valid = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            sample();
            n_tests++;
            if (busy !== (c % 5 != 0)) begin
                n_fail++;
                $display("FAIL single_busy c=%0d: got %b, expected %b", c, busy, (c % 5 != 0));
            end
            if (c % 5 != 0) begin
                n_tests++;
                if (grant_id !== 2'd2) begin
                    n_fail++;
                    $display("FAIL single_grant c=%0d: got %0d, expected 2", c, grant_id);
                end
            end
            tick();
        end
        req_valid = '0;
        sample();
        tick();
        drained("single_drain");
    endtask

    task automatic test_backpressure();
        logic       wr_e;
        logic       busy_e;
        logic [3:0] rdy_e;
        do_reset();
        push_exp(0, 4);
        for (int c = 0; c < 9; c++) begin
            fifo_full = (c >= 2 && c <= 4);
            req_valid = (c == 8) ? 4'b0000 : 4'b0001;
            busy_e = (c >= 1 && c <= 7);
            wr_e   = (c == 1) || (c >= 5 && c <= 7);
            rdy_e  = wr_e ? 4'b0001 : 4'b0000;
            sample();
            n_tests++;
            if (busy !== busy_e || fifo_wr_en !== wr_e || req_ready !== rdy_e) begin
                n_fail++;
                $display("FAIL bp_cycle c=%0d: got busy=%b wr=%b ready=%b, expected %b %b %b",
                         c, busy, fifo_wr_en, req_ready, busy_e, wr_e, rdy_e);
            end
            if (busy_e) begin
                n_tests++;
                if (grant_id !== 2'd0) begin
                    n_fail++;
                    $display("FAIL bp_owner c=%0d: got %0d, expected 0", c, grant_id);
                end
            end
            tick();
        end
        fifo_full = 1'b0;
        n_tests++;
        if (beat_count[15:0] !== 16'd4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d, expected 4", beat_count[15:0]);
        end
        drained("bp_drain");
    endtask

    task automatic test_drop();
        logic busy_e;
        logic wr_e;
        logic [1:0] gid_e;
        do_reset();
        push_exp(0, 2);
        push_exp(1, 4);
        push_exp(0, 1);
        for (int c = 0; c < 13; c++) begin
            req_valid = (c == 3) ? 4'b0010 : (c >= 11) ? 4'b0000 : 4'b0011;
            busy_e = (c >= 1 && c <= 3) || (c >= 5 && c <= 8) || c == 10 || c == 11;
            wr_e   = c == 1 || c == 2 || (c >= 5 && c <= 8) || c == 10;
            gid_e  = (c >= 5 && c <= 8) ? 2'd1 : 2'd0;
            sample();
            n_tests++;
            if (busy !== busy_e || fifo_wr_en !== wr_e) begin
                n_fail++;
                $display("FAIL drop_cycle c=%0d: got busy=%b wr=%b, expected %b %b",
                         c, busy, fifo_wr_en, busy_e, wr_e);
            end
            if (busy_e) begin
                n_tests++;
                if (grant_id !== gid_e) begin
                    n_fail++;
                    $display("FAIL drop_grant c=%0d: got %0d, expected %0d", c, grant_id, gid_e);
                end
            end
            if (c == 4) begin
                n_tests++;
                if (beat_count[15:0] !== 16'd2) begin
                    n_fail++;
                    $display("FAIL drop_count: got %0d, expected 2", beat_count[15:0]);
                end
            end
            tick();
        end
        n_tests++;
        if (beat_count[31:0] !== {16'd4, 16'd3}) begin
            n_fail++;
            $display("FAIL drop_final_counts: got %h, expected %h", beat_count[31:0], {16'd4, 16'd3});
        end
        drained("drop_drain");
    endtask

    task automatic test_reset_mid_burst();
        logic wr_e;
        do_reset();
        push_exp(0, 4);
        push_exp(1, 2);
        push_exp(0, 1);
        for (int c = 0; c < 13; c++) begin
            rst = (c == 8);
            req_valid = (c >= 11) ? 4'b0000 : (c >= 8) ? 4'b1001 : 4'b0011;
            wr_e = (c >= 1 && c <= 4) || c == 6 || c == 7 || c == 10;
            sample();
            n_tests++;
            if (fifo_wr_en !== wr_e) begin
                n_fail++;
                $display("FAIL rstmid_wr c=%0d: got %b, expected %b", c, fifo_wr_en, wr_e);
            end
            if (c == 9) begin
                n_tests++;
                if (busy !== 1'b0 || beat_count !== 64'd0 || grant_id !== 2'd0) begin
                    n_fail++;
                    $display("FAIL rstmid_after: got busy=%b counts=%h gid=%0d, expected 0 0 0",
                             busy, beat_count, grant_id);
                end
            end
            if (c == 10) begin
                n_tests++;
                if (busy !== 1'b1 || grant_id !== 2'd0) begin
                    n_fail++;
                    $display("FAIL rstmid_regrant: got busy=%b gid=%0d, expected 1 0", busy, grant_id);
                end
            end
            tick();
        end
        rst = 1'b0;
        drained("rstmid_drain");
    endtask

    task automatic test_burst1();
        logic       wr_e;
        logic [1:0] g;
        do_reset();
        rv1 = 4'hF;
        for (int c = 0; c < 9; c++) begin
            wr_e = (c % 2 == 1);
            g = 2'(((c - 1) / 2) % 4);
            sample();
            n_tests++;
            if (wr1 !== wr_e) begin
                n_fail++;
                $display("FAIL b1_wr c=%0d: got %b, expected %b", c, wr1, wr_e);
            end
            if (wr_e) begin
                n_tests++;
                if (gid1 !== g || wd1 !== beat_data(int'(g), 0)) begin
                    n_fail++;
                    $display("FAIL b1_grant c=%0d: got id=%0d data=%h, expected id=%0d data=%h",
                             c, gid1, wd1, g, beat_data(int'(g), 0));
                end
            end
            tick();
        end
        rv1 = '0;
        tick();
    endtask

    // Transfers of a lone requester after C cycles with 16-beat bursts and one idle cycle between.
    function automatic int sat_exp(int c);
        int t;
        t = c - ((c - 1) / 17 + 1);
        return (t > 65535) ? 65535 : t;
    endfunction

    task automatic test_saturate();
        int cyc;
        do_reset();
        rv16 = 4'b0001;
        cyc = 69630;
        repeat (cyc) @(negedge clk);
        #1;
        n_tests++;
        if (bc16[15:0] !== 16'(sat_exp(cyc))) begin
            n_fail++;
            $display("FAIL sat_near: got %h, expected %h", bc16[15:0], 16'(sat_exp(cyc)));
        end
        repeat (3) @(negedge clk);
        cyc = cyc + 3;
        #1;
        n_tests++;
        if (bc16[15:0] !== 16'(sat_exp(cyc))) begin
            n_fail++;
            $display("FAIL sat_hit: got %h, expected %h", bc16[15:0], 16'(sat_exp(cyc)));
        end
        repeat (40) @(negedge clk);
        #1;
        n_tests++;
        if (bc16 !== {48'd0, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL sat_hold: got %h, expected %h", bc16, {48'd0, 16'hFFFF});
        end
        rv16 = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_drop();
        test_reset_mid_burst();
        test_burst1();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
